// File: rtl/fma_pkg.sv
// Shared types and width helpers for the FMA front end (unpack, multiply, align).
package fma_pkg;

  // Operand class as seen by every downstream stage; ZERO must stay 0 so a
  // cleared register reads back as a zero operand.
  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } fma_cls_e;

  // Occupancy of the output register / skid register pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Integer bits in front of the fraction: Q2 for the multiplier inputs,
  // Q4 for the addend so it has headroom against the 2*MAN_W product.
  localparam int MA_INT_BITS = 2;
  localparam int MC_INT_BITS = 4;
  localparam int MC_FRAC_MUL = 2;

  // Packed IEEE word width.
  function automatic int word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Multiplier operand significand width (Q2.MAN_W).
  function automatic int ma_w(input int man_w);
    return man_w + MA_INT_BITS;
  endfunction

  // Addend significand width (Q4.(2*MAN_W)).
  function automatic int mc_w(input int man_w);
    return MC_FRAC_MUL * man_w + MC_INT_BITS;
  endfunction

  // True for classes that behave as a number in a product (not zero, not NaN).
  function automatic logic is_nonzero_num(input fma_cls_e cls);
    return (cls == CLS_SUB) || (cls == CLS_NORM) || (cls == CLS_INF);
  endfunction

endpackage

// File: rtl/fma_operand_decode.sv
// Combinational split of one IEEE word into sign, effective exponent,
// hidden bit, fraction and class.
module fma_operand_decode
  import fma_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [word_w(EXP_W, MAN_W)-1:0] word,
  output logic                            sign,
  output logic [EXP_W-1:0]                exp_eff,
  output logic                            hidden,
  output logic [MAN_W-1:0]                frac,
  output fma_cls_e                        cls
);

  localparam int N = word_w(EXP_W, MAN_W);

  logic [EXP_W-1:0] exp_fld;
  logic             exp_zero;
  logic             exp_max;
  logic             frac_zero;

  assign sign      = word[N-1];
  assign exp_fld   = word[N-2:MAN_W];
  assign frac      = word[MAN_W-1:0];
  assign exp_zero  = ~|exp_fld;
  assign exp_max   = &exp_fld;
  assign frac_zero = ~|frac;

  // Classify and restore the hidden bit; subnormals use exponent 1 so they
  // line up with the smallest normal without a separate shift.
  always_comb begin
    exp_eff = exp_fld;
    hidden  = 1'b1;
    cls     = CLS_NORM;
    if (exp_zero) begin
      hidden = 1'b0;
      if (frac_zero) begin
        cls     = CLS_ZERO;
        exp_eff = '0;
      end else begin
        cls     = CLS_SUB;
        exp_eff = EXP_W'(1);
      end
    end else if (exp_max) begin
      if (frac_zero) begin
        cls = CLS_INF;
      end else if (frac[MAN_W-1]) begin
        cls = CLS_QNAN;
      end else begin
        cls = CLS_SNAN;
      end
    end
  end

endmodule

// File: rtl/fma_operand_unpack.sv
// FMA operand unpacker: decodes A, B, C, flags invalid operations and
// registers the triple behind a valid/ready handshake with a 2-entry skid.
module fma_operand_unpack
  import fma_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [word_w(EXP_W, MAN_W)-1:0] data_a,
  input  logic [word_w(EXP_W, MAN_W)-1:0] data_b,
  input  logic [word_w(EXP_W, MAN_W)-1:0] data_c,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            sign_a,
  output logic                            sign_b,
  output logic                            sign_c,
  output logic [EXP_W-1:0]                exp_a,
  output logic [EXP_W-1:0]                exp_b,
  output logic [EXP_W-1:0]                exp_c,
  output logic [ma_w(MAN_W)-1:0]          m_a,
  output logic [ma_w(MAN_W)-1:0]          m_b,
  output logic [mc_w(MAN_W)-1:0]          m_c,
  output fma_cls_e                        cls_a,
  output fma_cls_e                        cls_b,
  output fma_cls_e                        cls_c,
  output logic                            invalid
);

  localparam int MA_W = ma_w(MAN_W);
  localparam int MC_W = mc_w(MAN_W);

  // One unpacked triple, exactly as presented on the output ports.
  typedef struct packed {
    logic             sign_a;
    logic             sign_b;
    logic             sign_c;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [EXP_W-1:0] exp_c;
    logic [MA_W-1:0]  m_a;
    logic [MA_W-1:0]  m_b;
    logic [MC_W-1:0]  m_c;
    fma_cls_e         cls_a;
    fma_cls_e         cls_b;
    fma_cls_e         cls_c;
    logic             invalid;
  } triple_t;

  logic             dec_sign_a, dec_sign_b, dec_sign_c;
  logic [EXP_W-1:0] dec_exp_a, dec_exp_b, dec_exp_c;
  logic             dec_hid_a, dec_hid_b, dec_hid_c;
  logic [MAN_W-1:0] dec_frac_a, dec_frac_b, dec_frac_c;
  fma_cls_e         dec_cls_a, dec_cls_b, dec_cls_c;

  fma_operand_decode #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_dec_a (
    .word    (data_a),
    .sign    (dec_sign_a),
    .exp_eff (dec_exp_a),
    .hidden  (dec_hid_a),
    .frac    (dec_frac_a),
    .cls     (dec_cls_a)
  );

  fma_operand_decode #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_dec_b (
    .word    (data_b),
    .sign    (dec_sign_b),
    .exp_eff (dec_exp_b),
    .hidden  (dec_hid_b),
    .frac    (dec_frac_b),
    .cls     (dec_cls_b)
  );

  fma_operand_decode #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_dec_c (
    .word    (data_c),
    .sign    (dec_sign_c),
    .exp_eff (dec_exp_c),
    .hidden  (dec_hid_c),
    .frac    (dec_frac_c),
    .cls     (dec_cls_c)
  );

  logic    any_snan;
  logic    inf_times_zero;
  logic    prod_inf;
  logic    inf_cancel;
  logic    new_invalid;
  triple_t new_triple;

  // Invalid-operation detection: signalling NaN anywhere, 0*INF, or an
  // infinite product meeting an infinite addend of the opposite sign.
  always_comb begin
    any_snan       = (dec_cls_a == CLS_SNAN) || (dec_cls_b == CLS_SNAN) ||
                     (dec_cls_c == CLS_SNAN);
    inf_times_zero = ((dec_cls_a == CLS_INF) && (dec_cls_b == CLS_ZERO)) ||
                     ((dec_cls_b == CLS_INF) && (dec_cls_a == CLS_ZERO));
    prod_inf       = ((dec_cls_a == CLS_INF) && is_nonzero_num(dec_cls_b)) ||
                     ((dec_cls_b == CLS_INF) && is_nonzero_num(dec_cls_a));
    inf_cancel     = prod_inf && (dec_cls_c == CLS_INF) &&
                     ((dec_sign_a ^ dec_sign_b) != dec_sign_c);
    new_invalid    = any_snan || inf_times_zero || inf_cancel;
  end

  // Assemble the triple; the addend is widened to Q4.(2*MAN_W) so it sits
  // on the same binary point as the full-width product.
  always_comb begin
    new_triple         = '0;
    new_triple.sign_a  = dec_sign_a;
    new_triple.sign_b  = dec_sign_b;
    new_triple.sign_c  = dec_sign_c;
    new_triple.exp_a   = dec_exp_a;
    new_triple.exp_b   = dec_exp_b;
    new_triple.exp_c   = dec_exp_c;
    new_triple.m_a     = {1'b0, dec_hid_a, dec_frac_a};
    new_triple.m_b     = {1'b0, dec_hid_b, dec_frac_b};
    new_triple.m_c     = {3'b000, dec_hid_c, dec_frac_c, {MAN_W{1'b0}}};
    new_triple.cls_a   = dec_cls_a;
    new_triple.cls_b   = dec_cls_b;
    new_triple.cls_c   = dec_cls_c;
    new_triple.invalid = new_invalid;
  end

  skid_state_e state_q, state_d;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        in_xfer;
  logic        out_xfer;
  logic        load_or_in;
  logic        load_or_sk;
  logic        load_sk;
  triple_t     or_q;
  triple_t     sk_q;

  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid_q && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  // Occupancy state and the registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  // Next occupancy and which register loads from where; ordering is kept
  // because SK only ever drains into OR.
  always_comb begin
    state_d    = state_q;
    load_or_in = 1'b0;
    load_or_sk = 1'b0;
    load_sk    = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d    = ST_ONE;
          load_or_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_xfer && !out_xfer) begin
          state_d = ST_TWO;
          load_sk = 1'b1;
        end else if (!in_xfer && out_xfer) begin
          state_d = ST_EMPTY;
        end else if (in_xfer && out_xfer) begin
          load_or_in = 1'b1;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          state_d    = ST_ONE;
          load_or_sk = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Output and skid registers; OR holds steady whenever it is not reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_q <= '0;
      sk_q <= '0;
    end else begin
      if (load_or_in) begin
        or_q <= new_triple;
      end else if (load_or_sk) begin
        or_q <= sk_q;
      end
      if (load_sk) begin
        sk_q <= new_triple;
      end
    end
  end

  assign sign_a  = or_q.sign_a;
  assign sign_b  = or_q.sign_b;
  assign sign_c  = or_q.sign_c;
  assign exp_a   = or_q.exp_a;
  assign exp_b   = or_q.exp_b;
  assign exp_c   = or_q.exp_c;
  assign m_a     = or_q.m_a;
  assign m_b     = or_q.m_b;
  assign m_c     = or_q.m_c;
  assign cls_a   = or_q.cls_a;
  assign cls_b   = or_q.cls_b;
  assign cls_c   = or_q.cls_c;
  assign invalid = or_q.invalid;

endmodule

// File: tb/tb_fma_operand_unpack.sv
// Scoreboard bench for fma_operand_unpack with hand-computed single-precision vectors.
module tb_fma_operand_unpack;
  import fma_pkg::*;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [24:0] M1  = 25'h0800000;
  localparam logic [49:0] MC1 = 50'h4000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic [31:0] data_c = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sign_a, sign_b, sign_c;
  logic [7:0]  exp_a, exp_b, exp_c;
  logic [24:0] m_a, m_b;
  logic [49:0] m_c;
  logic [2:0]  cls_a, cls_b, cls_c;
  logic        invalid;

  typedef struct packed {
    logic        sa, sb, sc;
    logic [7:0]  ea, eb, ec;
    logic [24:0] ma, mb;
    logic [49:0] mc;
    logic [2:0]  ca, cb, cc;
    logic        inv;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    accepted = 0;
  exp_t  mon_act;

  fma_operand_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_a    (data_a),
    .data_b    (data_b),
    .data_c    (data_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .sign_c    (sign_c),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .exp_c     (exp_c),
    .m_a       (m_a),
    .m_b       (m_b),
    .m_c       (m_c),
    .cls_a     (cls_a),
    .cls_b     (cls_b),
    .cls_c     (cls_c),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  // Hard stop if something wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mk(input logic sa, input logic sb, input logic sc,
                              input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec,
                              input logic [24:0] ma, input logic [24:0] mb, input logic [49:0] mc,
                              input logic [2:0] ca, input logic [2:0] cb, input logic [2:0] cc,
                              input logic inv);
    exp_t e;
    e = {sa, sb, sc, ea, eb, ec, ma, mb, mc, ca, cb, cc, inv};
    return e;
  endfunction

  function automatic exp_t cur_out();
    exp_t e;
    e = {sign_a, sign_b, sign_c, exp_a, exp_b, exp_c, m_a, m_b, m_c,
         cls_a, cls_b, cls_c, invalid};
    return e;
  endfunction

  task automatic check_output(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got s=%b%b%b e=%h/%h/%h ma=%h mb=%h mc=%h cls=%0d/%0d/%0d inv=%b, expected s=%b%b%b e=%h/%h/%h ma=%h mb=%h mc=%h cls=%0d/%0d/%0d inv=%b",
               name, act.sa, act.sb, act.sc, act.ea, act.eb, act.ec, act.ma, act.mb, act.mc,
               act.ca, act.cb, act.cc, act.inv, exp.sa, exp.sb, exp.sc, exp.ea, exp.eb, exp.ec,
               exp.ma, exp.mb, exp.mc, exp.ca, exp.cb, exp.cc, exp.inv);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present a triple (caller is at posedge+1), wait for acceptance, record expectation.
  task automatic apply_stimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input exp_t e);
    bit got = 0;
    data_a   = a;
    data_b   = b;
    data_c   = c;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(e);
        name_q.push_back(name);
        accepted++;
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_accept: got no acceptance in 50 cycles, expected in_ready", name);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for every expected triple to be seen at the output.
  task automatic drain(input string name);
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) begin
      @(posedge clk);
    end
    check_val(name, 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare on each output transfer, and check a stalled output
  // already shows the oldest expected triple.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      mon_act = cur_out();
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got out_valid=1, expected no pending triple");
      end else if (out_ready) begin
        check_output(name_q.pop_front(), mon_act, sb_q.pop_front());
      end else begin
        check_output({name_q[0], "_stall"}, mon_act, sb_q[0]);
      end
    end
  end

  logic [31:0] bp_a[5];
  exp_t        bp_e[5];

  initial begin
    bp_a[0] = 32'h3F800000; bp_e[0] = mk(0,0,0, 8'h7F,8'h7F,8'h7F, M1,M1,MC1, CLS_NORM,CLS_NORM,CLS_NORM, 0);
    bp_a[1] = 32'h40000000; bp_e[1] = mk(0,0,0, 8'h80,8'h7F,8'h7F, M1,M1,MC1, CLS_NORM,CLS_NORM,CLS_NORM, 0);
    bp_a[2] = 32'h40400000; bp_e[2] = mk(0,0,0, 8'h80,8'h7F,8'h7F, 25'h0C00000,M1,MC1, CLS_NORM,CLS_NORM,CLS_NORM, 0);
    bp_a[3] = 32'h40800000; bp_e[3] = mk(0,0,0, 8'h81,8'h7F,8'h7F, M1,M1,MC1, CLS_NORM,CLS_NORM,CLS_NORM, 0);
    bp_a[4] = 32'hBF800000; bp_e[4] = mk(1,0,0, 8'h7F,8'h7F,8'h7F, M1,M1,MC1, CLS_NORM,CLS_NORM,CLS_NORM, 0);

    // Reset state
    #12;
    check_val("reset_out_valid", 64'(out_valid), 64'd0);
    check_val("reset_in_ready", 64'(in_ready), 64'd1);
    check_output("reset_outputs", cur_out(), mk(0,0,0, 8'h00,8'h00,8'h00, 25'h0,25'h0,50'h0, CLS_ZERO,CLS_ZERO,CLS_ZERO, 0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Normal ones, with one-cycle latency
    apply_stimulus("one_x3", 32'h3F800000, 32'h3F800000, 32'h3F800000,
                   mk(0,0,0, 8'h7F,8'h7F,8'h7F, M1,M1,MC1, CLS_NORM,CLS_NORM,CLS_NORM, 0));
    check_val("latency_first", 64'(out_valid), 64'd1);
    apply_stimulus("sub_negzero", 32'h00000001, 32'h80000000, 32'h3F800000,
                   mk(0,1,0, 8'h01,8'h00,8'h7F, 25'h0000001,25'h0,MC1, CLS_SUB,CLS_ZERO,CLS_NORM, 0));
    apply_stimulus("inf_times_zero", 32'h7F800000, 32'h00000000, 32'h3F800000,
                   mk(0,0,0, 8'hFF,8'h00,8'h7F, M1,25'h0,MC1, CLS_INF,CLS_ZERO,CLS_NORM, 1));
    apply_stimulus("qnan_times_zero", 32'h7FC00000, 32'h00000000, 32'h3F800000,
                   mk(0,0,0, 8'hFF,8'h00,8'h7F, 25'h0C00000,25'h0,MC1, CLS_QNAN,CLS_ZERO,CLS_NORM, 0));
    apply_stimulus("snan_c", 32'h3F800000, 32'h3F800000, 32'h7F800001,
                   mk(0,0,0, 8'h7F,8'h7F,8'hFF, M1,M1,50'h4000_0080_0000, CLS_NORM,CLS_NORM,CLS_SNAN, 1));
    apply_stimulus("inf_minus_inf", 32'h7F800000, 32'h3F800000, 32'hFF800000,
                   mk(0,0,1, 8'hFF,8'h7F,8'hFF, M1,M1,MC1, CLS_INF,CLS_NORM,CLS_INF, 1));
    apply_stimulus("inf_plus_inf", 32'h7F800000, 32'h3F800000, 32'h7F800000,
                   mk(0,0,0, 8'hFF,8'h7F,8'hFF, M1,M1,MC1, CLS_INF,CLS_NORM,CLS_INF, 0));
    apply_stimulus("min_norm_max_sub", 32'h00800000, 32'h007FFFFF, 32'h00000000,
                   mk(0,0,0, 8'h01,8'h01,8'h00, M1,25'h07FFFFF,50'h0, CLS_NORM,CLS_SUB,CLS_ZERO, 0));
    apply_stimulus("zero_times_inf_maxc", 32'h80000000, 32'hFF800000, 32'h7F7FFFFF,
                   mk(1,1,0, 8'h00,8'hFF,8'hFE, 25'h0,M1,50'h7FFF_FF80_0000, CLS_ZERO,CLS_INF,CLS_NORM, 1));
    apply_stimulus("snan_b", 32'h3F800000, 32'h7FBFFFFF, 32'hBF800000,
                   mk(0,0,1, 8'h7F,8'hFF,8'h7F, M1,25'h0BFFFFF,MC1, CLS_NORM,CLS_SNAN,CLS_NORM, 1));
    apply_stimulus("neginf_sq_vs_inf", 32'hFF800000, 32'h7F800000, 32'h7F800000,
                   mk(1,0,0, 8'hFF,8'hFF,8'hFF, M1,M1,MC1, CLS_INF,CLS_INF,CLS_INF, 1));
    apply_stimulus("neginf_sq_same", 32'hFF800000, 32'hFF800000, 32'h7F800000,
                   mk(1,1,0, 8'hFF,8'hFF,8'hFF, M1,M1,MC1, CLS_INF,CLS_INF,CLS_INF, 0));
    drain("drain_directed");

    // Backpressure: five triples streamed, output stalled for three cycles
    out_ready = 1'b0;
    accepted  = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          apply_stimulus($sformatf("bp%0d", i), bp_a[i], 32'h3F800000, 32'h3F800000, bp_e[i]);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        check_val("bp_accepted_c2", 64'(accepted), 64'd2);
        check_val("bp_in_ready_c2", 64'(in_ready), 64'd0);
        @(posedge clk);
        #2;
        check_val("bp_accepted_c3", 64'(accepted), 64'd2);
        check_val("bp_in_ready_c3", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
      end
    join
    drain("drain_bp");
    check_val("bp_total_accepted", 64'(accepted), 64'd5);

    // Reset while both registers are full
    out_ready = 1'b0;
    apply_stimulus("rst_fill0", 32'h40000000, 32'h3F800000, 32'h3F800000, bp_e[1]);
    apply_stimulus("rst_fill1", 32'h40400000, 32'h3F800000, 32'h3F800000, bp_e[2]);
    check_val("two_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_async_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_async_in_ready", 64'(in_ready), 64'd1);
    sb_q.delete();
    name_q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_out_valid", 64'(out_valid), 64'd0);
    apply_stimulus("post_rst", 32'h40800000, 32'h3F800000, 32'h3F800000, bp_e[3]);
    check_val("post_rst_latency", 64'(out_valid), 64'd1);
    drain("drain_post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
